// File: rtl/alu_seq_if.sv
// Command channel for alu_seq: valid/ready handshake plus opcode and data.
// master drives op_valid/op_code/op_data; slave returns op_ready.
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] op_data;

    modport master (
        output op_valid,
        output op_code,
        output op_data,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op_code,
        input  op_data,
        output op_ready
    );
endinterface

// File: rtl/alu_seq.sv
// Sequencer around an external combinational ALU: IDLE -> EXEC -> WB per
// command. Ports: clk, rst_n, cmd (slave handshake), ALU operand/control
// outputs, ALU result/carry inputs, acc, out_data, flag_c, flag_z, done.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_seq_if.slave         cmd,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_mul_en,
    output logic             alu_sub_en,
    output logic             alu_shift_en,
    output logic [2:0]       alu_shift_pos,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] out_data,
    output logic             flag_c,
    output logic             flag_z,
    output logic             done
);

    localparam logic [2:0] OP_LDA = 3'd0;
    localparam logic [2:0] OP_LDB = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_OUT = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_t;

    state_t           state;
    logic             ready_q;
    logic [2:0]       code_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] out_q;

    logic             mul_d;
    logic             sub_d;
    logic             shift_d;

    // ALU mode for the incoming command, loaded into the control
    // registers on acceptance so they are live for exactly the EXEC cycle.
    always_comb begin
        mul_d   = 1'b0;
        sub_d   = 1'b0;
        shift_d = 1'b0;
        unique case (1'b1)
            cmd.op_code == OP_SUB: sub_d   = 1'b1;
            cmd.op_code == OP_SHL: shift_d = 1'b1;
            cmd.op_code == OP_MUL: mul_d   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ready_q       <= 1'b1;
            code_q        <= OP_NOP;
            data_q        <= '0;
            a_q           <= '0;
            b_q           <= '0;
            out_q         <= '0;
            flag_c        <= 1'b0;
            flag_z        <= 1'b0;
            done          <= 1'b0;
            alu_mul_en    <= 1'b0;
            alu_sub_en    <= 1'b0;
            alu_shift_en  <= 1'b0;
            alu_shift_pos <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (cmd.op_valid) begin
                        code_q        <= cmd.op_code;
                        data_q        <= cmd.op_data;
                        alu_mul_en    <= mul_d;
                        alu_sub_en    <= sub_d;
                        alu_shift_en  <= shift_d;
                        // shift amount only reaches the ALU for SHL
                        alu_shift_pos <= shift_d ? cmd.op_data[2:0] : 3'd0;
                        ready_q       <= 1'b0;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    alu_mul_en    <= 1'b0;
                    alu_sub_en    <= 1'b0;
                    alu_shift_en  <= 1'b0;
                    alu_shift_pos <= 3'd0;
                    done          <= 1'b1;
                    state         <= WB;
                    case (code_q)
                        OP_LDA: a_q <= data_q;
                        OP_LDB: b_q <= data_q;
                        OP_ADD, OP_SUB, OP_SHL: begin
                            a_q    <= alu_result;
                            flag_z <= (alu_result == '0);
                            flag_c <= alu_carry;
                        end
                        // MUL carry is not meaningful; keep the old flag
                        OP_MUL: begin
                            a_q    <= alu_result;
                            flag_z <= (alu_result == '0);
                        end
                        OP_OUT: out_q <= a_q;
                        OP_NOP: ;
                    endcase
                end
                WB: begin
                    done    <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign cmd.op_ready = ready_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign acc          = a_q;
    assign out_data     = out_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: behavioural ALU, command table, back-to-back
// handshake sequence and mid-command reset.
module tb_alu_seq;

    localparam logic [2:0] LDA = 3'd0;
    localparam logic [2:0] LDB = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] SUB = 3'd3;
    localparam logic [2:0] SHL = 3'd4;
    localparam logic [2:0] MUL = 3'd5;
    localparam logic [2:0] OUT = 3'd6;
    localparam logic [2:0] NOP = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_mul_en;
    logic       alu_sub_en;
    logic       alu_shift_en;
    logic [2:0] alu_shift_pos;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic [7:0] acc;
    logic [7:0] out_data;
    logic       flag_c;
    logic       flag_z;
    logic       done;

    int checks   = 0;
    int failures = 0;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd           (bus),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_mul_en    (alu_mul_en),
        .alu_sub_en    (alu_sub_en),
        .alu_shift_en  (alu_shift_en),
        .alu_shift_pos (alu_shift_pos),
        .alu_result    (alu_result),
        .alu_carry     (alu_carry),
        .acc           (acc),
        .out_data      (out_data),
        .flag_c        (flag_c),
        .flag_z        (flag_z),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Reference ALU: carry = carry-out for ADD, no-borrow for SUB,
    // last bit shifted out for SHL, product overflow for MUL.
    logic [8:0]  s9;
    logic [15:0] w16;
    always_comb begin
        s9         = 9'd0;
        w16        = 16'd0;
        alu_result = 8'd0;
        alu_carry  = 1'b0;
        if (alu_mul_en) begin
            w16        = {8'd0, alu_a} * {8'd0, alu_b};
            alu_result = w16[7:0];
            alu_carry  = |w16[15:8];
        end else if (alu_sub_en) begin
            s9         = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
            alu_result = s9[7:0];
            alu_carry  = s9[8];
        end else if (alu_shift_en) begin
            w16        = {8'd0, alu_a} << alu_shift_pos;
            alu_result = w16[7:0];
            alu_carry  = w16[8];
        end else begin
            s9         = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result = s9[7:0];
            alu_carry  = s9[8];
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk3(input string nm, input logic [2:0] act,
                        input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act,
                        input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Starts and ends on a falling edge. Checks fixed timing:
    // EXEC one cycle after accept, done in WB, idle again after.
    task automatic run_cmd(input string nm, input logic [2:0] code,
                           input logic [7:0] data, input logic [2:0] ectl,
                           input logic [2:0] epos);
        int n;
        n = 0;
        while (!bus.op_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk1({nm, " ready"}, bus.op_ready, 1'b1);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.op_data  = data;
        @(negedge clk);
        bus.op_valid = 1'b0;
        chk3({nm, " exec ctl"}, {alu_mul_en, alu_sub_en, alu_shift_en}, ectl);
        chk3({nm, " exec pos"}, alu_shift_pos, epos);
        chk1({nm, " exec done"}, done, 1'b0);
        chk1({nm, " exec ready"}, bus.op_ready, 1'b0);
        @(negedge clk);
        chk1({nm, " wb done"}, done, 1'b1);
        chk3({nm, " wb ctl"}, {alu_mul_en, alu_sub_en, alu_shift_en}, 3'b000);
        chk3({nm, " wb pos"}, alu_shift_pos, 3'd0);
        @(negedge clk);
        chk1({nm, " idle done"}, done, 1'b0);
        chk1({nm, " idle ready"}, bus.op_ready, 1'b1);
    endtask

    typedef struct {
        logic [2:0] code;
        logic [7:0] data;
        logic [7:0] acc;
        logic [7:0] outd;
        logic       c;
        logic       z;
        logic [2:0] ctl;
        logic [2:0] pos;
    } vec_t;

    vec_t vt[24];

    initial begin
        int   dn[$];
        int   idx;
        int   dcnt;
        vec_t sq[4];

        // ctl = {mul, sub, shift}
        vt[0]  = '{LDA, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 3'b000, 3'd0};
        vt[1]  = '{LDB, 8'h03, 8'h05, 8'h00, 1'b0, 1'b0, 3'b000, 3'd0};
        vt[2]  = '{ADD, 8'h00, 8'h08, 8'h00, 1'b0, 1'b0, 3'b000, 3'd0};
        vt[3]  = '{LDA, 8'h03, 8'h03, 8'h00, 1'b0, 1'b0, 3'b000, 3'd0};
        vt[4]  = '{SUB, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 3'b010, 3'd0};
        vt[5]  = '{LDA, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1, 3'b000, 3'd0};
        vt[6]  = '{LDB, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1, 3'b000, 3'd0};
        vt[7]  = '{ADD, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 3'b000, 3'd0};
        vt[8]  = '{LDA, 8'h81, 8'h81, 8'h00, 1'b1, 1'b1, 3'b000, 3'd0};
        vt[9]  = '{SHL, 8'h01, 8'h02, 8'h00, 1'b1, 1'b0, 3'b001, 3'd1};
        vt[10] = '{LDB, 8'h0F, 8'h02, 8'h00, 1'b1, 1'b0, 3'b000, 3'd0};
        vt[11] = '{LDA, 8'h34, 8'h34, 8'h00, 1'b1, 1'b0, 3'b000, 3'd0};
        vt[12] = '{MUL, 8'h00, 8'h0C, 8'h00, 1'b1, 1'b0, 3'b100, 3'd0};
        vt[13] = '{LDA, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 3'b000, 3'd0};
        vt[14] = '{ADD, 8'h00, 8'h1F, 8'h00, 1'b0, 1'b0, 3'b000, 3'd0};
        vt[15] = '{MUL, 8'h00, 8'hD1, 8'h00, 1'b0, 1'b0, 3'b100, 3'd0};
        vt[16] = '{SUB, 8'h00, 8'hC2, 8'h00, 1'b1, 1'b0, 3'b010, 3'd0};
        vt[17] = '{SHL, 8'hFB, 8'h10, 8'h00, 1'b0, 1'b0, 3'b001, 3'd3};
        vt[18] = '{LDA, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 3'b000, 3'd0};
        vt[19] = '{OUT, 8'h00, 8'h5A, 8'h5A, 1'b0, 1'b0, 3'b000, 3'd0};
        vt[20] = '{NOP, 8'hFF, 8'h5A, 8'h5A, 1'b0, 1'b0, 3'b000, 3'd0};
        vt[21] = '{LDB, 8'h00, 8'h5A, 8'h5A, 1'b0, 1'b0, 3'b000, 3'd0};
        vt[22] = '{MUL, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b1, 3'b100, 3'd0};
        vt[23] = '{NOP, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b1, 3'b000, 3'd0};

        rst_n        = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_code  = NOP;
        bus.op_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk8("rst acc", acc, 8'h00);
        chk8("rst out", out_data, 8'h00);
        chk1("rst c", flag_c, 1'b0);
        chk1("rst z", flag_z, 1'b0);
        chk1("rst done", done, 1'b0);
        chk1("rst ready", bus.op_ready, 1'b1);
        chk3("rst ctl", {alu_mul_en, alu_sub_en, alu_shift_en}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            run_cmd(nm, vt[i].code, vt[i].data, vt[i].ctl, vt[i].pos);
            chk8({nm, " acc"}, acc, vt[i].acc);
            chk8({nm, " out"}, out_data, vt[i].outd);
            chk1({nm, " c"}, flag_c, vt[i].c);
            chk1({nm, " z"}, flag_z, vt[i].z);
        end

        // op_valid held high across four commands
        sq[0] = '{LDA, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0, 3'b000, 3'd0};
        sq[1] = '{LDA, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0, 3'b000, 3'd0};
        sq[2] = '{OUT, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'b000, 3'd0};
        sq[3] = '{NOP, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'b000, 3'd0};
        idx = 0;
        for (int t = 0; t < 30; t++) begin
            if (done) dn.push_back(t);
            if (bus.op_ready) begin
                if (idx < 4) begin
                    bus.op_valid = 1'b1;
                    bus.op_code  = sq[idx].code;
                    bus.op_data  = sq[idx].data;
                    idx++;
                end else begin
                    bus.op_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        bus.op_valid = 1'b0;
        chkn("b2b done count", dn.size(), 4);
        if (dn.size() == 4) begin
            chkn("b2b first done", dn[0], 2);
            for (int k = 0; k < 3; k++)
                chkn($sformatf("b2b gap%0d", k), dn[k+1] - dn[k], 3);
        end
        chk8("b2b out", out_data, 8'h5A);
        chk8("b2b acc", acc, 8'h5A);

        // reset during EXEC of an ADD
        run_cmd("pre lda", LDA, 8'h40, 3'b000, 3'd0);
        run_cmd("pre ldb", LDB, 8'h01, 3'b000, 3'd0);
        chk8("pre acc", acc, 8'h40);
        bus.op_valid = 1'b1;
        bus.op_code  = ADD;
        bus.op_data  = 8'h00;
        @(negedge clk);
        bus.op_valid = 1'b0;
        chk1("abort in exec", bus.op_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk8("abort acc", acc, 8'h00);
        chk1("abort done", done, 1'b0);
        chk1("abort ready", bus.op_ready, 1'b1);
        chk3("abort ctl", {alu_mul_en, alu_sub_en, alu_shift_en}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chkn("abort no done", dcnt, 0);
        chk1("post ready", bus.op_ready, 1'b1);
        chk8("post acc", acc, 8'h00);
        chk1("post c", flag_c, 1'b0);
        run_cmd("post lda", LDA, 8'h07, 3'b000, 3'd0);
        chk8("post lda acc", acc, 8'h07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
- REQ-001: Parameter WIDTH, default 8, SHALL set the operand, accumulator and data width; only WIDTH=8 is required to be supported.
- REQ-002: clk  input  1  SHALL be the single clock; all state changes on its rising edge.
- REQ-003: rst_n  input  1  SHALL be the reset: asynchronous, active-low.
- REQ-004: op_valid  input  1  SHALL mark a command present on op_code/op_data.
- REQ-005: op_ready  output  1  SHALL indicate the block accepts a command this cycle.
- REQ-006: op_code  input  3  SHALL select the command: 000 LDA, 001 LDB, 010 ADD, 011 SUB, 100 SHL, 101 MUL, 110 OUT, 111 NOP.
- REQ-007: op_data  input  WIDTH  SHALL carry load data (LDA/LDB) or the shift amount in [2:0] (SHL).
- REQ-008: alu_a, alu_b  output  WIDTH each  SHALL drive the ALU operands from registers A and B.
- REQ-009: alu_mul_en, alu_sub_en, alu_shift_en  output  1 each  SHALL drive the ALU mode controls.
- REQ-010: alu_shift_pos  output  3  SHALL drive the ALU shift amount.
- REQ-011: alu_result  input  WIDTH; alu_carry  input  1  SHALL return the combinational ALU outputs.
- REQ-012: acc  output  WIDTH  SHALL expose register A.
- REQ-013: out_data  output  WIDTH  SHALL expose the output register.
- REQ-014: flag_c, flag_z  output  1 each  SHALL expose the carry and zero flags.
- REQ-015: done  output  1  SHALL pulse high for one cycle on command completion.

Function
- REQ-016: FSM states SHALL be IDLE, EXEC and WB.
- REQ-017: op_ready SHALL be high exactly when the state is IDLE.
- REQ-018: Acceptance (op_valid & op_ready) SHALL latch op_code, op_data[2:0] and op_data and move to EXEC; op_valid while not ready SHALL be ignored with no state change.
- REQ-019: EXEC SHALL last one cycle and always move to WB.
- REQ-020: WB SHALL last one cycle, assert done and return to IDLE.
- REQ-021: Fixed latency SHALL be: accept edge -> done high 2 cycles later; back-to-back throughput is one command per 3 cycles.
- REQ-022: ALU controls SHALL be 0 in IDLE and WB; in EXEC: ADD all 0; SUB alu_sub_en=1; SHL alu_shift_en=1 with alu_shift_pos=latched amount; MUL alu_mul_en=1; other codes all 0.
- REQ-023: alu_a=A and alu_b=B SHALL hold continuously.
- REQ-024: At the EXEC->WB edge, ADD/SUB/SHL/MUL SHALL write A<=alu_result and flag_z<=(alu_result==0).
- REQ-025: At the same edge, ADD/SUB/SHL SHALL write flag_c<=alu_carry; MUL SHALL leave flag_c unchanged.
- REQ-026: At the same edge, LDA SHALL write A<=op_data and LDB SHALL write B<=op_data; flags SHALL be unchanged.
- REQ-027: At the same edge, OUT SHALL write out_data<=A; NOP SHALL change no register; both SHALL still complete through WB with done.
- REQ-028: Arithmetic SHALL wrap modulo 2^WIDTH; the block SHALL not alter the ALU result.

Reset
- REQ-029: rst_n low SHALL immediately force state IDLE and A, B, out_data, flag_c, flag_z, done and all ALU controls to 0.
- REQ-030: Reset mid-command SHALL abort it with no register write and no done; op_ready SHALL be high on the first edge after release.

Verification
- REQ-031: LDA 0x05, LDB 0x03, ADD -> acc=0x08, flag_c=0, flag_z=0, one done per command, each 2 cycles after accept.
- REQ-032: LDA 0x03, LDB 0x03, SUB -> acc=0x00, flag_z=1, flag_c=1; then LDA 0xFF, LDB 0x01, ADD -> acc=0x00, flag_c=1, flag_z=1.
- REQ-033: LDA 0x81, SHL op_data=0x01 -> alu_shift_pos=1 in EXEC only, acc=0x02, flag_c=1; then MUL with A=0x34 -> acc=0x0C, flag_c unchanged.
- REQ-034: op_valid held high with 4 commands queued -> accepts only in IDLE, exactly 4 done pulses 3 cycles apart; OUT after LDA 0x5A -> out_data=0x5A, acc unchanged.
- REQ-035: rst_n low during EXEC of ADD -> no done, acc=0x00, op_ready=1 after release.
